evo_probe: RTL

- Test-harness stage wrapped around a 2-input/1-output evolved LCELL circuit.
- Upstream: drives the circuit's 2-bit input through all four vectors.
- Downstream: synchronises and samples the circuit's unclocked, possibly oscillating output.
- Per vector: reports ones count, toggle count and majority value. End of sweep: reports the 4-entry truth table and an oscillation flag for fitness evaluation.

---
 rtl/evo_probe_pkg.sv | 23 ++
 rtl/sync2.sv | 32 +++
 rtl/evo_probe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/evo_probe_pkg.sv
// Shared types and helpers for the evolved-circuit probe harness.
// Imported by evo_probe and its synchroniser.
package evo_probe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        REPORT,
        DONE
    } state_e;

    localparam int unsigned NUM_VECS = 4;

    // ones_x2 is twice the ones count, so a tie gives 0.
    function automatic logic majority(
        input int unsigned ones_x2,
        input int unsigned samples
    );
        return ones_x2 > samples;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for evolved-circuit outputs.
// Only q (the second flop) may be used downstream.
module sync2
    import evo_probe_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/evo_probe.sv
// Sweeps a 2-input evolved circuit through all input vectors and
// measures the ones count, toggles and majority level of its output.
module evo_probe
    import evo_probe_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SAMPLE_CYCLES = 256,
    parameter int unsigned CNT_W = $clog2(SAMPLE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [1:0]          dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                result_valid,
    output logic [1:0]          result_vec,
    output logic [CNT_W-1:0]    result_ones,
    output logic [CNT_W-1:0]    result_toggles,
    output logic                result_level,
    output logic                done,
    output logic [NUM_VECS-1:0] truth_table,
    output logic                oscillating
);

    localparam int unsigned MAX_CYC =
        (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int unsigned CYC_W = $clog2(MAX_CYC);

    state_e                state_q, state_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [1:0]            vec_q, vec_d;
    logic [1:0]            dut_in_q, dut_in_d;
    logic [CNT_W-1:0]      ones_q, ones_d;
    logic [CNT_W-1:0]      tog_q, tog_d;
    logic                  prev_q, prev_d;
    logic [NUM_VECS-1:0]   tt_q, tt_d;
    logic                  osc_q, osc_d;

    logic                  s2;
    logic [CNT_W:0]        ones_x2;
    logic                  level;
    logic                  report;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (dut_out),
        .q     (s2)
    );

    assign ones_x2 = {ones_q, 1'b0};
    assign level   = majority(32'(ones_x2), SAMPLE_CYCLES);

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        vec_d    = vec_q;
        dut_in_d = dut_in_q;
        ones_d   = ones_q;
        tog_d    = tog_q;
        prev_d   = prev_q;
        tt_d     = tt_q;
        osc_d    = osc_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    cyc_d    = '0;
                    vec_d    = 2'd0;
                    dut_in_d = 2'd0;
                    tt_d     = '0;
                    osc_d    = 1'b0;
                end
            end

            SETTLE: begin
                if (cyc_q == CYC_W'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                    cyc_d   = '0;
                    ones_d  = '0;
                    tog_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end

            SAMPLE: begin
                if (s2 && ones_q != '1) begin
                    ones_d = ones_q + CNT_W'(1);
                end
                // The first sample has no predecessor to compare with.
                if (cyc_q != '0 && s2 != prev_q && tog_q != '1) begin
                    tog_d = tog_q + CNT_W'(1);
                end
                prev_d = s2;
                if (cyc_q == CYC_W'(SAMPLE_CYCLES - 1)) begin
                    state_d = REPORT;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end

            REPORT: begin
                tt_d[vec_q] = level;
                osc_d       = osc_q | (tog_q != '0);
                if (vec_q == 2'(NUM_VECS - 1)) begin
                    state_d = DONE;
                end else begin
                    vec_d    = vec_q + 2'd1;
                    dut_in_d = vec_q + 2'd1;
                    cyc_d    = '0;
                    state_d  = SETTLE;
                end
            end

            DONE: begin
                state_d  = IDLE;
                dut_in_d = 2'd0;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            vec_q    <= 2'd0;
            dut_in_q <= 2'd0;
            ones_q   <= '0;
            tog_q    <= '0;
            prev_q   <= 1'b0;
            tt_q     <= '0;
            osc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            vec_q    <= vec_d;
            dut_in_q <= dut_in_d;
            ones_q   <= ones_d;
            tog_q    <= tog_d;
            prev_q   <= prev_d;
            tt_q     <= tt_d;
            osc_q    <= osc_d;
        end
    end

    assign report = (state_q == REPORT);

    assign dut_in         = dut_in_q;
    assign busy           = (state_q == SETTLE) || (state_q == SAMPLE) || report;
    assign result_valid   = report;
    assign result_vec     = report ? vec_q : 2'd0;
    assign result_ones    = report ? ones_q : '0;
    assign result_toggles = report ? tog_q : '0;
    assign result_level   = report & level;
    assign done           = (state_q == DONE);
    assign truth_table    = tt_q;
    assign oscillating    = osc_q;

endmodule
